// File: rtl/cpu_run_ctrl.sv
// Host-side run controller: debounced button to CPU continue pulses, debug word capture.
// Define CPU_RUN_BRK_EN to add the brk_value/brk_hit breakpoint-on-debug-value feature.
module cpu_run_ctrl #(
    parameter int unsigned DBNC_CYCLES = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_step,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] burst_len,
    input  logic [31:0]      debug_in,
`ifdef CPU_RUN_BRK_EN
    input  logic [31:0]      brk_value,
    output logic             brk_hit,
`endif
    output logic             cont_out,
    output logic [31:0]      debug_latched,
    output logic             busy,
    output logic [CNT_W-1:0] step_count
);

    localparam int unsigned DW = $clog2(DBNC_CYCLES);
    localparam logic [DW-1:0] DBNC_LAST = DW'(DBNC_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StPulse, StCapture, StRun} state_e;

    state_e           state_q;
    logic [1:0]       sync_q;
    logic [DW-1:0]    dbnc_cnt_q;
    logic             db_level_q;
    logic             press_q;
    logic [CNT_W-1:0] remaining_q;
    logic             run_block_q;
    logic [CNT_W-1:0] step_inc;
    logic             brk_match;

    assign step_inc = (step_count == '1) ? step_count : step_count + 1'b1;

`ifdef CPU_RUN_BRK_EN
    assign brk_match = (debug_in == brk_value);
`else
    assign brk_match = 1'b0;
`endif

    // Level flips only after DBNC_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= 2'b00;
            dbnc_cnt_q <= '0;
            db_level_q <= 1'b0;
            press_q    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_step};
            press_q <= 1'b0;
            if (sync_q[1] != db_level_q) begin
                if (dbnc_cnt_q == DBNC_LAST) begin
                    db_level_q <= sync_q[1];
                    dbnc_cnt_q <= '0;
                    press_q    <= sync_q[1];
                end else begin
                    dbnc_cnt_q <= dbnc_cnt_q + 1'b1;
                end
            end else begin
                dbnc_cnt_q <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            cont_out      <= 1'b0;
            busy          <= 1'b0;
            debug_latched <= '0;
            step_count    <= '0;
            remaining_q   <= '0;
            run_block_q   <= 1'b0;
        end else begin
            cont_out <= 1'b0;
            if (mode != 2'b11) run_block_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (mode == 2'b11 && !run_block_q) begin
                        state_q    <= StRun;
                        cont_out   <= 1'b1;
                        busy       <= 1'b1;
                        step_count <= step_inc;
                    end else if (press_q && mode == 2'b01) begin
                        state_q     <= StPulse;
                        cont_out    <= 1'b1;
                        busy        <= 1'b1;
                        step_count  <= step_inc;
                        remaining_q <= '0;
                    end else if (press_q && mode == 2'b10 && burst_len != '0) begin
                        state_q     <= StPulse;
                        cont_out    <= 1'b1;
                        busy        <= 1'b1;
                        step_count  <= step_inc;
                        remaining_q <= burst_len - 1'b1;
                    end
                end
                StPulse: begin
                    state_q <= StCapture;
                end
                StCapture: begin
                    debug_latched <= debug_in;
                    if (mode == 2'b00 || brk_match) begin
                        state_q     <= StIdle;
                        busy        <= 1'b0;
                        remaining_q <= '0;
                    end else if (remaining_q != '0) begin
                        remaining_q <= remaining_q - 1'b1;
                        state_q     <= StPulse;
                        cont_out    <= 1'b1;
                        step_count  <= step_inc;
                    end else begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                end
                StRun: begin
                    debug_latched <= debug_in;
                    if (mode == 2'b11 && !brk_match) begin
                        cont_out   <= 1'b1;
                        step_count <= step_inc;
                    end else begin
                        state_q     <= StIdle;
                        busy        <= 1'b0;
                        remaining_q <= '0;
                        // A breakpoint in free run must not immediately re-enter RUN.
                        if (brk_match && mode == 2'b11) run_block_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef CPU_RUN_BRK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            brk_hit <= 1'b0;
        end else if ((state_q == StCapture || state_q == StRun) && brk_match) begin
            brk_hit <= 1'b1;
        end else if (state_q == StIdle && press_q) begin
            brk_hit <= 1'b0;
        end
    end
`endif

endmodule
